quad_encoder_bank: RTL
======================

# quad_encoder_bank

Multi-channel quadrature rotary-encoder front end: CHANNELS independent encoders, each with a two-flop input synchroniser, per-bit debounce filter, full Gray-code decoding with a configurable edges-per-detent divider, speed-dependent increment (acceleration) and a saturating or wrapping value register. It sits between the board encoder pins and the PWM/colour logic. It adds parallel load, direction, change and illegal-transition outputs.

## Interface
- CHANNELS, 3: number of encoder channels; minimum 1.
- WIDTH, 8: bits per channel value.
- DEBOUNCE, 4: consecutive cycles a synchronised bit must differ from its filtered value before the filter follows it; minimum 1.
- STEP_EDGES, 4: valid Gray edges per counted step; legal values 1, 2 and 4.
- INC_SLOW, 1: increment applied to a step when the step is not fast.
- INC_FAST, 4: increment applied to a step that follows the previous step of that channel within FAST_WINDOW cycles.
- FAST_WINDOW, 1000: acceleration window in clk cycles; minimum 1.
- SATURATE, 1: 1 = clamp at 0 and 2^WIDTH-1; 0 = modulo 2^WIDTH wrap.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- a  in  CHANNELS  encoder A pins, asynchronous, one bit per channel.
- b  in  CHANNELS  encoder B pins, asynchronous, one bit per channel.
- load  in  1  write load_value into the channel selected by load_sel.
- load_sel  in  max(1,clog2(CHANNELS))  target channel; out-of-range values are ignored.
- load_value  in  WIDTH  value to load.
- value  out  CHANNELS*WIDTH  packed values; channel n occupies [n*WIDTH +: WIDTH].
- changed  out  CHANNELS  one-cycle pulse on the edge that updates the channel value from a step.
- dir  out  CHANNELS  direction of the last step: 1 = up (A leads B), 0 = down.
- illegal  out  CHANNELS  one-cycle pulse when both filtered bits change on the same edge.

## Operation
- Synchroniser: two flops per pin, s1 then s2.
- Debounce: each bit has a counter cnt and a filtered value f.
  - If s2 equals f: cnt clears to 0.
  - Otherwise, if cnt equals DEBOUNCE-1: f takes s2 and cnt clears.
  - Otherwise cnt increments.
- Decoder: registers fd, the previous f, and compares {fd, f} each cycle.
  - Up edges: 00→10, 10→11, 11→01, 01→00 (written {A,B}). These increment a signed sub-count.
  - Down edges: the reverse sequence. These decrement the sub-count.
  - Both bits changed: illegal pulses; the sub-count and value are unchanged.
- Step generation:
  - When the sub-count reaches +STEP_EDGES, an up step fires and the sub-count clears to 0.
  - When it reaches -STEP_EDGES, a down step fires and the sub-count clears to 0.
  - A direction reversal mid-detent moves the sub-count back toward 0; no step fires.
- Acceleration: a per-channel gap counter increments each cycle and saturates at FAST_WINDOW. On every step it clears to 0.
  - A step taken while the gap counter is below FAST_WINDOW is fast and uses INC_FAST.
  - Any other step uses INC_SLOW.
- Arithmetic: the increment is computed at WIDTH+1 bits.
  - SATURATE=1: an up step with value+inc > 2^WIDTH-1 yields 2^WIDTH-1; a down step with inc > value yields 0.
  - SATURATE=0: the result is the low WIDTH bits.
  - changed pulses on every step, including steps whose result is clamped to an unchanged value.
- Load: a load on channel n overrides any step on channel n in the same cycle.
  - The step is discarded; changed and dir do not update.
  - The sub-count and gap counter are unaffected.
  - Other channels step normally.

## Timing
- Reset values:
  - value 0, changed 0, dir 0, illegal 0.
  - s1, s2, f, fd all 0; cnt 0; sub-count 0; gap counter FAST_WINDOW, so the first step after reset is slow.
- Pins at 11 when reset releases produce one illegal pulse; no step fires.
- A mid-operation reset clears all state on that edge, including a partially accumulated sub-count.
- Latency: a pin change first sampled on edge k updates f on edge k+1+DEBOUNCE. The resulting edge is decoded and value, changed and dir update on edge k+2+DEBOUNCE.
- Glitches shorter than DEBOUNCE cycles of s2 never reach f.
- A load is visible on value the edge after load is sampled high.
- Channels are fully independent; simultaneous steps on all channels update in the same cycle.

## Test plan
- Reset, then one slow forward detent on ch0 (STEP_EDGES=4, each phase held 8 cycles, spaced more than FAST_WINDOW apart):
  - Required: value0 goes 0→1; one changed pulse; dir0=1.
  - Required: that pulse comes exactly DEBOUNCE+2 edges after the sampling edge of the fourth transition.
- Ten fast reverse detents on ch1 after load of 20:
  - Required: the first step gives 19, because the gap counter is saturated after the load setup.
  - Required: the following steps subtract 4 each, saturating at 0 on the 6th detent (19→15→11→7→3→0).
  - Required: remaining steps hold 0 and still pulse changed.
- SATURATE=0, load 254, three slow up steps:
  - Required: 255, 0, 1.
- 2-cycle glitch on A with DEBOUNCE=4:
  - Required: no change in f, value or changed.
  - Then force A and B to flip together: required is one illegal pulse and value unchanged.
- Half detent forward then back, STEP_EDGES=4:
  - Required: no step fires; the next full forward detent yields exactly +1.
- load on ch2 in the same cycle as a ch2 step and a ch0 step:
  - Required: ch2 equals load_value with no changed pulse; ch0 steps normally.

Source files
------------

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder front end: sync, debounce, Gray decode,
// detent divider, speed-dependent increment and saturating/wrapping value.

module quad_encoder_channel #(
    parameter int WIDTH       = 8,
    parameter int DEBOUNCE    = 4,
    parameter int STEP_EDGES  = 4,
    parameter int INC_SLOW    = 1,
    parameter int INC_FAST    = 4,
    parameter int FAST_WINDOW = 1000,
    parameter int SATURATE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             load_hit,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             dir,
    output logic             illegal
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int GAP_W = $clog2(FAST_WINDOW + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(FAST_WINDOW);
    localparam logic signed [3:0] SE_P    = 4'(STEP_EDGES);
    localparam logic signed [3:0] SE_N    = -SE_P;
    localparam logic [WIDTH:0]    INC_S   = (WIDTH+1)'(INC_SLOW);
    localparam logic [WIDTH:0]    INC_F   = (WIDTH+1)'(INC_FAST);

    // bit 1 carries A, bit 0 carries B, so each vector reads {A,B}
    logic [1:0]       s1, s2, f, fd;
    logic [CNT_W-1:0] cnt [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            f  <= '0;
            fd <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= {a, b};
            s2 <= s1;
            fd <= f;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Gray {A,B} -> position 00=0,10=1,11=2,01=3; position delta classifies the edge
    logic [1:0] ph_f, ph_fd, delta;
    logic       edge_up, edge_dn, edge_ill;

    assign ph_f     = {f[0], f[1] ^ f[0]};
    assign ph_fd    = {fd[0], fd[1] ^ fd[0]};
    assign delta    = ph_f - ph_fd;
    assign edge_up  = (delta == 2'd1);
    assign edge_dn  = (delta == 2'd3);
    assign edge_ill = (delta == 2'd2);

    logic signed [3:0] sub, sub_nxt;
    logic              step_up, step_dn, step;

    always_comb begin
        sub_nxt = sub;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (edge_up) begin
            if (sub == SE_P - 4'sd1) begin
                step_up = 1'b1;
                sub_nxt = '0;
            end else begin
                sub_nxt = sub + 4'sd1;
            end
        end else if (edge_dn) begin
            if (sub == SE_N + 4'sd1) begin
                step_dn = 1'b1;
                sub_nxt = '0;
            end else begin
                sub_nxt = sub - 4'sd1;
            end
        end
    end

    assign step = step_up | step_dn;

    logic [GAP_W-1:0] gap;
    logic             fast;
    logic [WIDTH:0]   ext, inc, sum, diff;
    logic [WIDTH-1:0] value_nxt;

    assign fast = (gap < GAP_MAX);

    always_comb begin
        ext  = {1'b0, value};
        inc  = fast ? INC_F : INC_S;
        sum  = ext + inc;
        diff = ext - inc;
        if (step_up)
            value_nxt = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        else
            value_nxt = (SATURATE != 0 && inc > ext) ? '0 : diff[WIDTH-1:0];
    end

    // A load wins over a coincident step, but the step still retires the
    // sub-count and restarts the gap timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            value   <= '0;
            changed <= 1'b0;
            dir     <= 1'b0;
            illegal <= 1'b0;
            sub     <= '0;
            gap     <= GAP_MAX;
        end else begin
            sub     <= sub_nxt;
            illegal <= edge_ill;
            if (step)
                gap <= '0;
            else if (gap != GAP_MAX)
                gap <= gap + 1'b1;
            if (load_hit) begin
                value   <= load_value;
                changed <= 1'b0;
            end else begin
                changed <= step;
                if (step) begin
                    value <= value_nxt;
                    dir   <= step_up;
                end
            end
        end
    end
endmodule

module quad_encoder_bank #(
    parameter int CHANNELS    = 3,
    parameter int WIDTH       = 8,
    parameter int DEBOUNCE    = 4,
    parameter int STEP_EDGES  = 4,
    parameter int INC_SLOW    = 1,
    parameter int INC_FAST    = 4,
    parameter int FAST_WINDOW = 1000,
    parameter int SATURATE    = 1,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic                      load,
    input  logic [SEL_W-1:0]          load_sel,
    input  logic [WIDTH-1:0]          load_value,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       illegal
);
    logic [CHANNELS-1:0][WIDTH-1:0] ch_value;
    logic [CHANNELS-1:0]            load_hit;

    assign value = ch_value;

    for (genvar n = 0; n < CHANNELS; n++) begin : gen_ch
        // out-of-range selects simply match no channel
        assign load_hit[n] = load && (load_sel == SEL_W'(n));

        quad_encoder_channel #(
            .WIDTH      (WIDTH),
            .DEBOUNCE   (DEBOUNCE),
            .STEP_EDGES (STEP_EDGES),
            .INC_SLOW   (INC_SLOW),
            .INC_FAST   (INC_FAST),
            .FAST_WINDOW(FAST_WINDOW),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .a         (a[n]),
            .b         (b[n]),
            .load_hit  (load_hit[n]),
            .load_value(load_value),
            .value     (ch_value[n]),
            .changed   (changed[n]),
            .dir       (dir[n]),
            .illegal   (illegal[n])
        );
    end
endmodule
